fetch_unit: RTL and testbench

//   Instruction fetch stage feeding decode. Holds the architectural PC and fetches one
//   32-bit word at a time over a request/valid instruction-memory port. Presents the

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-word imem fetch, hold-until-consumed
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_input_sel,
    input  logic [31:0] branch_target,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);
    typedef enum logic [1:0] {S_REQ = 2'd0, S_VALID = 2'd1, S_FAULT = 2'd2} state_t;

    localparam int            CW       = $clog2(IMEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_cause;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_next_pc;
    logic          w_timeout;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Bit 0 of a jump target is dropped as JALR does; bit 1 still flags misalignment.
    assign w_next_pc  = pc_input_sel ? {branch_target[31:1], 1'b0} : w_pc_plus4;
    assign w_timeout  = (r_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_REQ;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (imem_rvalid)    w_state_next = S_VALID;
                else if (w_timeout) w_state_next = S_FAULT;
            end
            S_VALID: begin
                if (instr_ready) w_state_next = w_next_pc[1] ? S_FAULT : S_REQ;
            end
            default: w_state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_cnt   <= '0;
            r_cause <= 2'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_cause <= 2'd2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        if (w_next_pc[1]) r_cause <= 2'd1;
                        else              r_pc    <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so a stale state never leaks a request.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        instr       = NOP_INSTR;
        if (!reset) begin
            case (r_state)
                S_REQ:   imem_req = 1'b1;
                S_VALID: begin
                    instr_valid = 1'b1;
                    instr       = r_instr;
                end
                default: fetch_fault = 1'b1;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fault_cause = r_cause;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_input_sel = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic        mem_on = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(RPC), .IMEM_TIMEOUT(16), .NOP_INSTR(NOP)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .pc_input_sel(pc_input_sel), .branch_target(branch_target),
        .fetch_fault(fetch_fault), .fault_cause(fault_cause)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rvalid = mem_on & imem_req;
    assign imem_rdata  = mem_on ? word_at(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        logic [31:0] e;
        int n = 0;
        while (instr_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, pc, e);
            chk({tag, "_instr"}, instr, word_at(e));
            chk({tag, "_pc4"}, pc_plus4, e + 32'd4);
        end
    endtask

    // Consume the held word; returns at the negedge after the consuming edge.
    task automatic consume(input logic sel, input logic [31:0] tgt);
        pc_input_sel  = sel;
        branch_target = tgt;
        instr_ready   = 1'b1;
        @(posedge clock);
        #1;
        instr_ready  = 1'b0;
        pc_input_sel = 1'b0;
        @(negedge clock);
    endtask

    task automatic fetch_step(input string tag, input logic sel, input logic [31:0] tgt,
                              input logic [31:0] nxt);
        exp_q.push_back(nxt);
        consume(sel, tgt);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, nxt);
        chk({tag, "_vld0"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clock);
        wait_valid(tag);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_vld", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_pc", pc, RPC);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        chk("rst_req1", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, RPC);
    endtask

    initial begin
        int n;
        // 1: reset then first fetch from RESET_PC with zero-wait memory
        repeat (3) @(posedge clock);
        mem_on = 1'b1;
        exp_q.push_back(RPC);
        pulse_reset();
        @(negedge clock);
        wait_valid("first");

        // 2: sequential fetches
        fetch_step("seq1", 1'b0, 32'h0, 32'h104);
        fetch_step("seq2", 1'b0, 32'h0, 32'h108);
        fetch_step("seq3", 1'b0, 32'h0, 32'h10C);

        // 3: stall with noisy branch inputs
        pc_input_sel = 1'b1;
        for (int i = 0; i < 10; i++) begin
            branch_target = (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_0002;
            @(negedge clock);
            chk("stall_pc", pc, 32'h10C);
            chk("stall_instr", instr, word_at(32'h10C));
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        pc_input_sel = 1'b0;
        fetch_step("after_stall", 1'b0, 32'h0, 32'h110);

        // 4: branch with bit0 set, then misaligned branch
        fetch_step("br_bit0", 1'b1, 32'h0000_2001, 32'h2000);
        consume(1'b1, 32'h0000_2002);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_cause", {30'd0, fault_cause}, 32'd1);
        chk("mis_pc", pc, 32'h2000);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_instr", instr, NOP);
        repeat (3) @(negedge clock);
        chk("mis_sticky", {31'd0, fetch_fault}, 32'd1);

        // 6a: reset out of S_FAULT
        exp_q.push_back(RPC);
        pulse_reset();
        @(negedge clock);
        wait_valid("from_fault");

        // 5: memory never answers
        mem_on = 1'b0;
        consume(1'b0, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (fetch_fault === 1'b1) break;
            if (imem_req === 1'b1) n++;
            @(negedge clock);
        end
        chk("to_cycles", n, 32'd16);
        chk("to_fault", {31'd0, fetch_fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd2);
        repeat (2) @(negedge clock);
        chk("to_noreq", {31'd0, imem_req}, 32'd0);

        // 6b: reset while a request is outstanding
        pulse_reset();
        repeat (3) @(negedge clock);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        mem_on = 1'b1;
        exp_q.push_back(RPC);
        pulse_reset();
        @(negedge clock);
        wait_valid("mid_req");

        // 6c: pc+4 wrap
        fetch_step("to_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch_step("wrap", 1'b0, 32'h0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
